// File: rtl/aes256_unloading_pkg.sv
// Shared types and widths for the byte-serial ciphertext unloader.
package aes256_unloading_pkg;

   localparam int BYTES_PER_BLOCK = 16;
   localparam int BLOCK_W         = 128;
   localparam int BYTE_W          = 8;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, PUSH} state_t;

endpackage

// File: rtl/aes256_unloading_if.sv
// Byte request handshake towards aes256_loading plus the block valid/ready output.
interface aes256_unloading_if
   import aes256_unloading_pkg::*;
   ();

   logic               pi_enc_done;
   logic               po_next_val_req;
   logic               pi_next_val_ready;
   logic [BYTE_W-1:0]  pi_data;
   logic               po_block_valid;
   logic [BLOCK_W-1:0] po_block;
   logic               pi_block_ready;

   modport master (
      output pi_enc_done, pi_next_val_ready, pi_data, pi_block_ready,
      input  po_next_val_req, po_block_valid, po_block
   );

   modport slave (
      input  pi_enc_done, pi_next_val_ready, pi_data, pi_block_ready,
      output po_next_val_req, po_block_valid, po_block
   );

endinterface

// File: rtl/aes256_block_fifo.sv
// Synchronous FIFO of wide blocks; head is read straight from the storage registers.
module aes256_block_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_pop;

   assign valid  = (fill != '0);
   assign do_pop = pop && valid;
   // Empty FIFO presents zero so the unreset storage never leaks onto the port.
   assign head   = valid ? mem[rd_ptr] : '0;

   // NOTE: the storage array has no reset; only pointers and count define its contents.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, do_pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

endmodule

// File: rtl/aes256_unloading.sv
// Fetches 16 ciphertext bytes per enc_done pulse, packs them MSB-first and queues the block.
module aes256_unloading
   import aes256_unloading_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   aes256_unloading_if.slave             bus,
   output logic [$clog2(FIFO_DEPTH):0]   po_fill_level,
   output logic                          po_busy,
   output logic                          po_timeout_err,
   output logic                          po_overrun_err,
   input  logic                          pi_clear_err
);

   localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FILL_W-1:0] DEPTH_L   = FILL_W'(FIFO_DEPTH);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]        LAST_BYTE = 4'(BYTES_PER_BLOCK - 1);

   state_t             state;
   logic               pending;
   logic [3:0]         byte_cnt;
   logic [TMO_W-1:0]   tmo_cnt;
   logic [BLOCK_W-1:0] shift_reg;
   logic               start;
   logic               fifo_valid;
   logic [BLOCK_W-1:0] fifo_head;

   // Space is reserved at block start, so PUSH can never find the FIFO full.
   assign start   = (state == IDLE) && pending && (po_fill_level < DEPTH_L);
   assign po_busy = (state != IDLE) || pending;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state               <= IDLE;
         pending             <= 1'b0;
         byte_cnt            <= '0;
         tmo_cnt             <= '0;
         shift_reg           <= '0;
         bus.po_next_val_req <= 1'b0;
         po_timeout_err      <= 1'b0;
         po_overrun_err      <= 1'b0;
      end else begin
         bus.po_next_val_req <= 1'b0;

         // Clear first; a same-cycle error assignment below overrides it.
         if (pi_clear_err) begin
            po_timeout_err <= 1'b0;
            po_overrun_err <= 1'b0;
         end

         if (bus.pi_enc_done) begin
            pending <= 1'b1;
            if (pending && !start) po_overrun_err <= 1'b1;
         end else if (start) begin
            pending <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state               <= REQ;
                  byte_cnt            <= '0;
                  bus.po_next_val_req <= 1'b1;
               end
            end
            REQ: begin
               state   <= WAIT;
               tmo_cnt <= '0;
            end
            WAIT: begin
               if (bus.pi_next_val_ready) begin
                  shift_reg <= {shift_reg[BLOCK_W-BYTE_W-1:0], bus.pi_data};
                  byte_cnt  <= byte_cnt + 1'b1;
                  if (byte_cnt == LAST_BYTE) begin
                     state <= PUSH;
                  end else begin
                     state               <= REQ;
                     bus.po_next_val_req <= 1'b1;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  po_timeout_err <= 1'b1;
                  shift_reg      <= '0;
                  byte_cnt       <= '0;
                  state          <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            PUSH: begin
               state     <= IDLE;
               shift_reg <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   aes256_block_fifo #(
      .WIDTH (BLOCK_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (state == PUSH),
      .wdata (shift_reg),
      .pop   (bus.pi_block_ready),
      .head  (fifo_head),
      .valid (fifo_valid),
      .fill  (po_fill_level)
   );

   assign bus.po_block       = fifo_head;
   assign bus.po_block_valid = fifo_valid;

endmodule

// File: tb/tb_aes256_unloading.sv
// Directed bench: FIPS-197 vector, backpressure, overrun, timeout, async reset, streaming wrap.
module tb_aes256_unloading;
   import aes256_unloading_pkg::*;

   localparam logic [127:0] FIPS = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] fill;
   logic       busy, tmo_err, ovr_err, clear_err;

   int n_checks  = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int req_total = 0;

   aes256_unloading_if bus();

   aes256_unloading #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .po_fill_level  (fill),
      .po_busy        (busy),
      .po_timeout_err (tmo_err),
      .po_overrun_err (ovr_err),
      .pi_clear_err   (clear_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.po_next_val_req) req_total <= req_total + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] pat(input int k);
      pat = FIPS ^ {16{8'(k + 1)}};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_enc();
      bus.pi_enc_done = 1'b1;
      @(negedge clk);
      bus.pi_enc_done = 1'b0;
   endtask

   task automatic wait_req(input int budget, output bit seen);
      int n = 0;
      while (!bus.po_next_val_req && n < budget) begin
         @(negedge clk);
         n++;
      end
      seen = bus.po_next_val_req;
   endtask

   // Answers each request one cycle later; optionally adds a junk ready in REQ or an enc_done pulse.
   task automatic serve(input logic [127:0] blk, input int nbytes, input bit spurious,
                        input logic [15:0] enc_mask);
      bit seen;
      for (int i = 0; i < nbytes; i++) begin
         wait_req(100, seen);
         if (!seen) begin
            check("req_seen", 128'(seen), 128'(1));
            return;
         end
         if (spurious) begin
            bus.pi_next_val_ready = 1'b1;
            bus.pi_data           = 8'hff;
         end
         @(negedge clk);
         bus.pi_next_val_ready = 1'b1;
         bus.pi_data           = blk[127-8*i -: 8];
         bus.pi_enc_done       = enc_mask[i];
         @(negedge clk);
         bus.pi_next_val_ready = 1'b0;
         bus.pi_data           = 8'h00;
         bus.pi_enc_done       = 1'b0;
      end
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!bus.po_block_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(tag, 128'(bus.po_block_valid), 128'(1));
   endtask

   task automatic pop_check(input string tag, input logic [127:0] exp);
      check(tag, bus.po_block, exp);
      bus.pi_block_ready = 1'b1;
      @(negedge clk);
      bus.pi_block_ready = 1'b0;
   endtask

   initial begin
      int t_enc, r0, n;
      bit seen;
      logic [127:0] exp_q[$];

      rst                   = 1'b1;
      clear_err             = 1'b0;
      bus.pi_enc_done       = 1'b0;
      bus.pi_next_val_ready = 1'b0;
      bus.pi_data           = 8'h00;
      bus.pi_block_ready    = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_flags", 128'({bus.po_next_val_req, bus.po_block_valid, fill, busy, tmo_err, ovr_err}), 128'(0));
      check("reset_block", bus.po_block, 128'(0));
      rst = 1'b0;
      @(negedge clk);

      // FIPS-197 block: valid rises 34 edges after the edge that samples enc_done.
      r0    = req_total;
      t_enc = cyc + 1;
      pulse_enc();
      serve(FIPS, 16, 1'b0, 16'h0);
      wait_valid("fips_valid");
      check("fips_latency", 128'(cyc - t_enc), 128'(34));
      check("fips_block", bus.po_block, FIPS);
      check("fips_fill", 128'(fill), 128'(1));
      repeat (4) @(negedge clk);
      check("fips_req_count", 128'(req_total - r0), 128'(16));
      check("fips_hold", bus.po_block, FIPS);
      pop_check("fips_pop", FIPS);
      check("fips_empty", 128'({bus.po_block_valid, fill}), 128'(0));

      // Backpressure: four blocks fill the FIFO, the fifth waits for a pop.
      for (int b = 0; b < 4; b++) begin
         pulse_enc();
         serve(pat(b), 16, 1'b0, 16'h0);
         repeat (6) @(negedge clk);
      end
      check("bp_fill_full", 128'(fill), 128'(4));
      r0 = req_total;
      pulse_enc();
      repeat (40) @(negedge clk);
      check("bp_no_req", 128'(req_total - r0), 128'(0));
      check("bp_busy_pending", 128'(busy), 128'(1));
      pop_check("bp_pop0", pat(0));
      serve(pat(4), 16, 1'b0, 16'h0);
      repeat (2) @(negedge clk);
      check("bp_refill", 128'(fill), 128'(4));
      for (int b = 1; b < 5; b++) pop_check("bp_order", pat(b));
      check("bp_drained", 128'(fill), 128'(0));
      check("bp_no_overrun", 128'(ovr_err), 128'(0));

      // Overrun: enc_done at byte 3 re-arms pending, enc_done at byte 6 overruns.
      pulse_enc();
      serve(pat(5), 16, 1'b0, 16'h0048);
      check("ovr_set", 128'(ovr_err), 128'(1));
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      check("ovr_cleared", 128'(ovr_err), 128'(0));
      check("ovr_first_block", bus.po_block, pat(5));
      serve(pat(6), 16, 1'b0, 16'h0);
      repeat (2) @(negedge clk);
      check("ovr_fill", 128'(fill), 128'(2));
      pop_check("ovr_pop_a", pat(5));
      pop_check("ovr_pop_b", pat(6));
      check("ovr_idle", 128'(busy), 128'(0));

      // Timeout: responder goes quiet; error lands after the REQ cycle plus 64 WAIT cycles.
      pulse_enc();
      serve(pat(7), 7, 1'b0, 16'h0);
      wait_req(10, seen);
      check("tmo_req_seen", 128'(seen), 128'(1));
      n = 0;
      while (!tmo_err && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("tmo_cycles", 128'(n), 128'(65));
      check("tmo_no_block", 128'({bus.po_block_valid, fill, busy}), 128'(0));
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      check("tmo_cleared", 128'(tmo_err), 128'(0));
      pulse_enc();
      serve(FIPS, 16, 1'b0, 16'h0);
      wait_valid("tmo_next_valid");
      pop_check("tmo_next_block", FIPS);

      // Spurious ready in IDLE and REQ, then async reset in the middle of a block.
      bus.pi_next_val_ready = 1'b1;
      bus.pi_data           = 8'h5a;
      @(negedge clk);
      bus.pi_next_val_ready = 1'b0;
      bus.pi_data           = 8'h00;
      pulse_enc();
      serve(pat(8), 16, 1'b1, 16'h0);
      wait_valid("spur_valid");
      check("spur_block", bus.po_block, pat(8));
      pulse_enc();
      serve(pat(9), 10, 1'b0, 16'h0);
      check("rst_pre_req", 128'(bus.po_next_val_req), 128'(1));
      rst = 1'b1;
      #1;
      check("rst_async_flags", 128'({bus.po_next_val_req, bus.po_block_valid, fill, busy, tmo_err, ovr_err}), 128'(0));
      check("rst_async_block", bus.po_block, 128'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      pulse_enc();
      serve(pat(10), 16, 1'b0, 16'h0);
      wait_valid("rst_next_valid");
      pop_check("rst_next_block", pat(10));
      check("rst_next_empty", 128'(fill), 128'(0));

      // Streaming: two blocks parked, then push and pop on the same edge across pointer wrap.
      for (int k = 0; k < 2; k++) begin
         pulse_enc();
         serve(pat(20 + k), 16, 1'b0, 16'h0);
         exp_q.push_back(pat(20 + k));
         repeat (3) @(negedge clk);
      end
      check("stream_prefill", 128'(fill), 128'(2));
      for (int k = 2; k < 10; k++) begin
         pulse_enc();
         serve(pat(20 + k), 16, 1'b0, 16'h0);
         exp_q.push_back(pat(20 + k));
         pop_check("stream_head", exp_q.pop_front());
         check("stream_fill", 128'(fill), 128'(2));
      end
      while (exp_q.size() > 0) pop_check("stream_drain", exp_q.pop_front());
      check("stream_empty", 128'(fill), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/aes256_unloading.md
Name: aes256_unloading

Overview:
- Consumer on the byte-serial output side of aes256_loading.
- After each encryption-done pulse it requests the 16 ciphertext bytes one at a time over the next_val_req/next_val_ready handshake and reassembles them into a 128-bit block.
- Completed blocks are buffered in a small FIFO and presented downstream on a valid/ready interface.
- Sits between aes256_loading and the host/scoreboard-side consumer.

Parameters:
- FIFO_DEPTH, 4, number of 128-bit blocks buffered; power of two, ≥2.
- TIMEOUT_CYCLES, 64, maximum cycles waited in WAIT for pi_next_val_ready before aborting the block.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- pi_enc_done  input  1  one-cycle pulse from aes256_loading: a ciphertext block is available.
- po_next_val_req  output  1  one-cycle pulse requesting the next ciphertext byte.
- pi_next_val_ready  input  1  one-cycle pulse: pi_data holds the requested byte this cycle.
- pi_data  input  8  ciphertext byte.
- po_block_valid  output  1  FIFO head valid.
- po_block  output  128  FIFO head block; first received byte in [127:120].
- pi_block_ready  input  1  downstream accepts the head when high with po_block_valid.
- po_fill_level  output  $clog2(FIFO_DEPTH)+1  blocks currently in the FIFO.
- po_busy  output  1  FSM not in IDLE or a block is pending.
- po_timeout_err  output  1  sticky: a byte request timed out.
- po_overrun_err  output  1  sticky: enc_done arrived with the pending flag already set.
- pi_clear_err  input  1  synchronous clear of both sticky errors.

Behaviour:
- Reset (async, any state): all outputs 0, FSM=IDLE, FIFO empty, byte_cnt=0, pending=0, shift register=0. Reset mid-block discards the partial block.
- Pending flag:
  - Set by pi_enc_done.
  - Cleared when the FSM leaves IDLE to start a block.
  - pi_enc_done while pending=1 sets po_overrun_err; pending stays 1 (request not queued twice).
  - pi_enc_done in the same cycle as the pending clear re-sets pending (no overrun).
- FSM states:
  - IDLE: if pending and (fill_level + 0) < FIFO_DEPTH, go to REQ with byte_cnt=0; otherwise stay.
  - REQ: po_next_val_req=1 for exactly this cycle; go to WAIT; timeout counter cleared.
  - WAIT:
    - On pi_next_val_ready: shift_reg <= {shift_reg[119:0], pi_data}; byte_cnt++. If byte_cnt was 15, go to PUSH, else go to REQ.
    - Else timeout counter++. At TIMEOUT_CYCLES: set po_timeout_err, discard the partial block, go to IDLE.
  - PUSH: write shift_reg to the FIFO (space guaranteed by the IDLE check); go to IDLE.
- pi_next_val_ready outside WAIT is ignored (no shift, no count).
- Latency:
  - Minimum 2 cycles per byte (REQ+WAIT with ready in the first WAIT cycle).
  - Block enters the FIFO 33 cycles after leaving IDLE; po_block_valid rises the cycle after PUSH.
- FIFO:
  - Registered head; push and pop in the same cycle allowed, fill level unchanged.
  - Pop on po_block_valid && pi_block_ready.
  - Full check happens only at block start, so PUSH never sees a full FIFO.
  - Read/write pointers wrap modulo FIFO_DEPTH; fill level counts 0..FIFO_DEPTH.
- po_block holds stable while valid and not popped.
- pi_clear_err together with a new error event in the same cycle: the error wins (stays set).

Decomposition:
- aes256_unloading_pkg:
  - state enum {IDLE, REQ, WAIT, PUSH}.
  - BYTES_PER_BLOCK=16.
  - BLOCK_W=128, BYTE_W=8.
- Sub-module aes256_block_fifo: parameterised width/depth synchronous FIFO with push, pop, head, fill level. Clock/reset identical to the parent.

Test Plan:
- FIPS-197 AES-256 vector: enc_done pulse, responder returns bytes 8e a2 b7 ca 51 67 45 bf ea fc 49 90 4b 49 60 89 one cycle after each req -> po_block=128'h8ea2b7ca516745bfeafc49904b496089, valid 34 cycles after enc_done, 16 req pulses total.
- Backpressure: pi_block_ready=0, 5 enc_done pulses spaced 40 cycles, FIFO_DEPTH=4 -> fill_level saturates at 4, fifth block not fetched (no req) until one pop, then fetched; no overrun since only one pending.
- Overrun: two enc_done pulses while first block is mid-fetch and pending already set by the second -> third pulse sets po_overrun_err; pi_clear_err clears it next cycle.
- Timeout: responder stops after byte 7 -> po_timeout_err after TIMEOUT_CYCLES=64 cycles in WAIT, no block pushed, next enc_done fetches a full correct block.
- Spurious ready in IDLE/REQ and reset asserted at byte 10 -> no shift, outputs return to 0 asynchronously, FIFO empty, subsequent block correct.
- Simultaneous push/pop with FIFO holding 2 blocks -> fill_level stays 2, order preserved across pointer wrap (10 blocks streamed).
